// File: rtl/data_ram_slave.sv
// Word-organised RAM slave on a falling-edge bus: request latch, programmable wait
// states, then a single access held in ACK until the master drops its request.
module data_ram_slave #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        read,
    input  logic        write,
    input  logic [2:0]  memType,
    input  logic [31:0] dataOut,
    output logic [31:0] dataIn,
    output logic        ready,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    localparam logic [2:0] MT_BYTE = 3'd0;
    localparam logic [2:0] MT_WORD = 3'd1;

    logic [1:0]    state_reg;
    logic [3:0]    cnt_reg;
    logic [31:0]   addr_reg;
    logic [31:0]   wdata_reg;
    logic [2:0]    mtype_reg;
    logic          rd_reg;
    logic          wr_reg;
    logic          ready_reg;
    logic          err_reg;
    logic          out_zero_reg;
    logic          out_byte_reg;
    logic [1:0]    out_lane_reg;

    logic [31:0]   a_sel;
    logic [31:0]   d_sel;
    logic [2:0]    m_sel;
    logic          r_sel;
    logic          w_sel;
    logic          req_err;
    logic          enter_ack;
    logic          do_write;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;

    // With zero wait states the access happens on the sample edge itself,
    // so the live bus must stand in for the not-yet-latched request registers.
    always_comb begin
        a_sel = addr_reg;
        d_sel = wdata_reg;
        m_sel = mtype_reg;
        r_sel = rd_reg;
        w_sel = wr_reg;
        if (state_reg == IDLE) begin
            a_sel = addr;
            d_sel = dataOut;
            m_sel = memType;
            r_sel = read;
            w_sel = write;
        end
    end

    assign word_idx  = a_sel[AW+1:2];
    assign req_err   = ((a_sel >> (AW + 2)) != 32'd0)
                     || (m_sel != MT_BYTE && m_sel != MT_WORD)
                     || (m_sel == MT_WORD && a_sel[1:0] != 2'd0)
                     || (r_sel && w_sel);
    assign enter_ack = (state_reg == IDLE && (read || write) && WAIT_STATES == 0)
                     || (state_reg == BUSY && cnt_reg == 4'd1);
    assign do_write  = enter_ack && w_sel && !req_err && !rst;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            addr_reg     <= 32'd0;
            wdata_reg    <= 32'd0;
            mtype_reg    <= 3'd0;
            rd_reg       <= 1'b0;
            wr_reg       <= 1'b0;
            ready_reg    <= 1'b0;
            err_reg      <= 1'b0;
            out_zero_reg <= 1'b1;
            out_byte_reg <= 1'b0;
            out_lane_reg <= 2'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (read || write) begin
                        addr_reg  <= addr;
                        wdata_reg <= dataOut;
                        mtype_reg <= memType;
                        rd_reg    <= read;
                        wr_reg    <= write;
                        if (WAIT_STATES == 0) begin
                            state_reg <= ACK;
                            ready_reg <= 1'b1;
                            err_reg   <= req_err;
                        end else begin
                            state_reg <= BUSY;
                            cnt_reg   <= 4'(WAIT_STATES);
                        end
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg <= ACK;
                        ready_reg <= 1'b1;
                        err_reg   <= req_err;
                    end
                end
                ACK: begin
                    if (!read && !write) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b0;
                        err_reg   <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
            // Output formatting is frozen at ACK entry so dataIn holds afterwards.
            if (enter_ack) begin
                out_zero_reg <= req_err || !r_sel;
                out_byte_reg <= (m_sel == MT_BYTE);
                out_lane_reg <= a_sel[1:0];
            end
        end
    end

    // One byte-wide RAM per lane gives per-lane write enables for byte stores.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rd_q;
            logic       we;

            assign we = do_write && (m_sel == MT_WORD || a_sel[1:0] == 2'(gi));

            always_ff @(negedge clk) begin
                if (we)
                    mem[word_idx] <= (m_sel == MT_WORD) ? d_sel[8*gi +: 8] : d_sel[7:0];
                if (enter_ack && !rst)
                    rd_q <= mem[word_idx];
            end

            assign rd_word[8*gi +: 8] = rd_q;
        end
    endgenerate

    always_comb begin
        dataIn = rd_word;
        if (out_zero_reg)
            dataIn = 32'd0;
        else if (out_byte_reg)
            dataIn = {24'd0, rd_word[8*out_lane_reg +: 8]};
    end

    assign ready = ready_reg;
    assign err   = err_reg;
endmodule

// File: tb/tb_data_ram_slave.sv
// Randomised bench for data_ram_slave: two instances (2 and 0 wait states) checked
// against a word-addressed reference memory with the access/error rules.
module tb_data_ram_slave;
    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        read;
    logic        write;
    logic [2:0]  memType;
    logic [31:0] dataOut;
    logic        sel0;
    logic [31:0] dataIn;
    logic        ready;
    logic        err;
    logic [31:0] dataIn0;
    logic        ready0;
    logic        err0;

    int vectors;
    int miscompares;

    bit [31:0] mdl [int];

    data_ram_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst), .addr(addr),
        .read(read & ~sel0), .write(write & ~sel0),
        .memType(memType), .dataOut(dataOut),
        .dataIn(dataIn), .ready(ready), .err(err)
    );

    data_ram_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .addr(addr),
        .read(read & sel0), .write(write & sel0),
        .memType(memType), .dataOut(dataOut),
        .dataIn(dataIn0), .ready(ready0), .err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus transaction; outputs are sampled 1 time unit after each falling edge.
    task automatic xact(input bit s, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [2:0] mt, input logic [31:0] d, input int hold);
        bit        e;
        int        key;
        bit [31:0] w;
        bit [31:0] exp_d;
        int        edges;
        int        lat;
        e   = (a >= 32'd4096) || (mt > 3'd1) || (mt == 3'd1 && a[1:0] != 2'd0) || (rd && wr);
        key = int'(s) * 65536 + int'(a[11:2]);
        w   = mdl.exists(key) ? mdl[key] : 32'd0;
        exp_d = 32'd0;
        if (!e && rd)
            exp_d = (mt == 3'd1) ? w : ((w >> (8 * a[1:0])) & 32'hFF);
        lat = s ? 1 : 3;

        @(posedge clk);
        sel0 = s; addr = a; memType = mt; dataOut = d; read = rd; write = wr;
        edges = 0;
        do begin
            @(negedge clk); #1;
            edges++;
            if (!(s ? ready0 : ready)) begin
                addr = $urandom; dataOut = $urandom; memType = 3'($urandom);
            end
        end while (!(s ? ready0 : ready) && edges < 40);
        chk("latency", edges, lat);
        chk("err", 32'(s ? err0 : err), 32'(e));
        if (rd || e) chk("data", s ? dataIn0 : dataIn, exp_d);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            chk("hold_ready", 32'(s ? ready0 : ready), 32'd1);
            if (rd || e) chk("hold_data", s ? dataIn0 : dataIn, exp_d);
        end
        @(posedge clk);
        read = 1'b0; write = 1'b0;
        @(negedge clk); #1;
        chk("release_ready", 32'(s ? ready0 : ready), 32'd0);
        chk("release_err", 32'(s ? err0 : err), 32'd0);
        if (rd || e) chk("idle_data", s ? dataIn0 : dataIn, exp_d);

        if (!e && wr) begin
            if (mt == 3'd1) mdl[key] = d;
            else begin
                w = (w & ~(32'hFF << (8 * a[1:0]))) | ((d & 32'hFF) << (8 * a[1:0]));
                mdl[key] = w;
            end
        end
    endtask

    initial begin
        bit          s;
        bit          rd;
        bit          wr;
        int          op;
        logic [2:0]  mt;
        logic [31:0] a;
        vectors = 0; miscompares = 0;
        rst = 1'b1; sel0 = 1'b0; addr = 0; read = 0; write = 0; memType = 0; dataOut = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_data", dataIn, 32'd0);
        chk("rst_ready0", 32'(ready0), 32'd0);
        chk("rst_data0", dataIn0, 32'd0);
        @(posedge clk); rst = 1'b0;

        // Word and byte accesses around 0x10
        xact(0, 0, 1, 32'h10, 3'd1, 32'hDEADBEEF, 0);
        xact(0, 1, 0, 32'h10, 3'd1, 32'h0, 0);
        xact(0, 0, 1, 32'h12, 3'd0, 32'hAAAAAA55, 0);
        xact(0, 1, 0, 32'h10, 3'd1, 32'h0, 0);
        xact(0, 1, 0, 32'h13, 3'd0, 32'h0, 0);

        for (int k = 0; k < 16; k++) begin
            if (k != 4) xact(0, 0, 1, 32'(4 * k), 3'd1, (k == 8) ? 32'd0 : $urandom, 0);
            xact(1, 0, 1, 32'(4 * k), 3'd1, $urandom, 0);
        end

        // Faulting accesses must leave memory untouched
        xact(0, 1, 0, 32'h06, 3'd1, 32'h0, 0);
        xact(0, 1, 0, 32'd4096, 3'd0, 32'h0, 0);
        xact(0, 1, 1, 32'h04, 3'd1, 32'hFFFFFFFF, 0);
        xact(0, 1, 0, 32'h04, 3'd1, 32'h0, 0);
        xact(0, 1, 0, 32'h04, 3'd5, 32'h0, 1);

        xact(0, 1, 0, 32'h10, 3'd1, 32'h0, 5);
        xact(0, 0, 1, 32'h09, 3'd0, 32'h77, 3);
        xact(0, 1, 0, 32'h08, 3'd1, 32'h0, 0);
        xact(1, 0, 1, 32'h30, 3'd1, 32'hCAFEF00D, 2);
        xact(1, 1, 0, 32'h31, 3'd0, 32'h0, 5);

        for (int i = 0; i < 80; i++) begin
            s  = 1'($urandom_range(0, 1));
            op = $urandom_range(0, 9);
            rd = (op < 5) || (op == 9);
            wr = (op >= 5);
            mt = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
            a  = ($urandom_range(0, 9) == 0) ? 32'(4096 + $urandom_range(0, 100000))
                                             : 32'($urandom_range(0, 63));
            xact(s, rd, wr, a, mt, $urandom, $urandom_range(0, 2));
        end

        // Reset in the middle of a pending word write to 0x20
        xact(0, 1, 0, 32'h10, 3'd1, 32'h0, 0);
        @(posedge clk);
        sel0 = 1'b0; addr = 32'h20; memType = 3'd1; dataOut = 32'h12345678; write = 1'b1;
        @(negedge clk); #1;
        chk("busy_ready", 32'(ready), 32'd0);
        @(posedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_data", dataIn, 32'd0);
        write = 1'b0;
        @(negedge clk);
        @(posedge clk); rst = 1'b0;
        xact(0, 1, 0, 32'h20, 3'd1, 32'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/data_ram_slave.md
DATA_RAM_SLAVE -- requirements
Module: data_ram_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 2, extra busy cycles before acknowledge (0..15).
REQ-003 SHALL have port clk input 1, the single clock; all state changes on the falling edge per bus convention.
REQ-004 SHALL have port rst input 1, asynchronous active-high reset.
REQ-005 SHALL have port addr input 32, byte address from master.
REQ-006 SHALL have port read input 1, read request level.
REQ-007 SHALL have port write input 1, write request level.
REQ-008 SHALL have port memType input 3, access size: BYTE=0, WORD=1, others reserved.
REQ-009 SHALL have port dataOut input 32, write data from master.
REQ-010 SHALL have port dataIn output 32, read data to master.
REQ-011 SHALL have port ready output 1, access complete.
REQ-012 SHALL have port err output 1, access faulted, valid while ready=1.
REQ-013 Ports addr..ready SHALL map one-to-one onto the DataBus slave modport.

Function
REQ-014 FSM states SHALL be IDLE, BUSY, ACK.
REQ-015 IDLE: on a falling edge with read|write=1, SHALL latch addr, memType, dataOut, op into request registers; go BUSY with counter=WAIT_STATES, or ACK directly if WAIT_STATES=0.
REQ-016 BUSY: counter SHALL decrement per falling edge; at counter=1 go ACK; bus input changes during BUSY ignored.
REQ-017 On entry to ACK SHALL perform the latched access exactly once and assert ready=1.
REQ-018 ACK: ready and dataIn SHALL hold until a falling edge sees read=0 and write=0, then ready=0, err=0, go IDLE.
REQ-019 Latency SHALL be WAIT_STATES+1 falling edges from request sample to ready=1.
REQ-020 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; lane SHALL be addr[1:0], little-endian (lane 0 = bits 7:0).
REQ-021 WORD read SHALL return the full word; BYTE read SHALL return selected lane zero-extended in dataIn[7:0].
REQ-022 WORD write SHALL store dataOut; BYTE write SHALL store dataOut[7:0] into selected lane only, other lanes unchanged.
REQ-023 Error SHALL be flagged (err=1 with ready=1, no memory change, dataIn=0) if: addr >= 4*DEPTH_WORDS; WORD with addr[1:0]!=0; memType reserved; read and write both 1 at sample.
REQ-024 In IDLE and BUSY, ready=0 and err=0; dataIn SHALL hold its last value.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, counter 0, ready=0, err=0, dataIn=0, request registers 0.
REQ-026 Memory contents SHALL NOT be reset; a write in BUSY when rst asserts SHALL NOT be committed.
REQ-027 After rst deasserts, first request sample SHALL occur on the next falling edge.

Verification
REQ-028 WORD write 0xDEADBEEF @0x10, then WORD read @0x10, WAIT_STATES=2 -> ready high 3 falling edges after each sample; read dataIn=0xDEADBEEF, err=0.
REQ-029 After REQ-028, BYTE write 0x55 @0x12, WORD read @0x10 -> 0xDE55BEEF; BYTE read @0x13 -> 0x000000DE.
REQ-030 WORD read @0x06, BYTE read @4*DEPTH_WORDS, read+write both 1 -> each err=1, ready=1, dataIn=0; memory word @0x04 unchanged.
REQ-031 Hold read high 5 cycles after ready -> ready/dataIn stable throughout; single access; ready drops on first edge with read=0; WAIT_STATES=0 build -> ready after 1 falling edge.
REQ-032 Assert rst during BUSY of WORD write 0x12345678 @0x20 (prior 0) -> ready=0, dataIn=0 immediately; subsequent read @0x20 returns 0x00000000.
